// File: rtl/timer_mode_ctrl.sv
// Stopwatch/countdown timer controller: two debounced push-buttons drive an
// IDLE/RUN/PAUSE/DONE FSM; a prescaler generates the 1-second tick.
module timer_mode_ctrl #(
  parameter int TICK_DIV  = 50000000,
  parameter int DB_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_start,
  input  logic [7:0] preset,
  output logic       sel,
  output logic [7:0] count,
  output logic       running,
  output logic       done
);

  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam int PW  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_CYCLES - 1);
  localparam logic [PW-1:0]  PRE_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  // Button front end, index 0 = mode, 1 = start
  logic [1:0]          btn_raw;
  logic [1:0]          s1_q, s2_q, vld_q;
  logic [1:0]          db_q, db_d, armed_q, armed_d, press_q, press_d;
  logic [1:0][DBW-1:0] dbc_q, dbc_d;

  assign btn_raw = {btn_start, btn_mode};

  // A button held through reset is not armed until its synchronised level is seen low.
  always_comb begin
    db_d    = db_q;
    dbc_d   = dbc_q;
    press_d = '0;
    armed_d = armed_q;
    for (int i = 0; i < 2; i++) begin
      armed_d[i] = armed_q[i] | (vld_q[1] & ~s2_q[i]);
      if (s2_q[i] == db_q[i]) begin
        dbc_d[i] = '0;
      end else if (dbc_q[i] == DB_LAST) begin
        db_d[i]    = s2_q[i];
        dbc_d[i]   = '0;
        press_d[i] = s2_q[i] & armed_q[i];
      end else begin
        dbc_d[i] = dbc_q[i] + DBW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      vld_q   <= '0;
      db_q    <= '0;
      dbc_q   <= '0;
      armed_q <= '0;
      press_q <= '0;
    end else begin
      s1_q    <= btn_raw;
      s2_q    <= s1_q;
      vld_q   <= {vld_q[0], 1'b1};
      db_q    <= db_d;
      dbc_q   <= dbc_d;
      armed_q <= armed_d;
      press_q <= press_d;
    end
  end

  // Mode FSM and timer datapath
  state_t          state_q, state_d;
  logic            sel_q, sel_d;
  logic [7:0]      count_q, count_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic            running_q, done_q;
  logic            mode_ev, start_ev, tick;

  assign mode_ev  = press_q[0];
  assign start_ev = press_q[1];
  assign tick     = (pre_q == PRE_LAST);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    count_d = count_q;
    pre_d   = pre_q;
    case (state_q)
      IDLE: begin
        if (start_ev) begin
          state_d = RUN;
          pre_d   = '0;
          count_d = sel_q ? preset : 8'd0;
        end else if (mode_ev) begin
          sel_d   = ~sel_q;
          count_d = sel_q ? 8'd0 : preset;
        end
      end
      RUN: begin
        pre_d = tick ? '0 : pre_q + PW'(1);
        if (start_ev) state_d = PAUSE;
        // Terminal conditions override a simultaneous pause request.
        if (!sel_q) begin
          if (tick) begin
            if (count_q == 8'hFF) state_d = DONE;
            else                  count_d = count_q + 8'd1;
          end
        end else if (count_q == 8'd0) begin
          state_d = DONE;
        end else if (tick) begin
          count_d = count_q - 8'd1;
          if (count_q == 8'd1) state_d = DONE;
        end
      end
      PAUSE: begin
        if (start_ev) state_d = RUN;
      end
      DONE: begin
        if (start_ev) begin
          state_d = IDLE;
          count_d = sel_q ? preset : 8'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sel_q     <= 1'b0;
      count_q   <= 8'd0;
      pre_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      count_q   <= count_d;
      pre_q     <= pre_d;
      running_q <= (state_d == RUN);
      done_q    <= (state_d == DONE);
    end
  end

  assign sel     = sel_q;
  assign count   = count_q;
  assign running = running_q;
  assign done    = done_q;

endmodule

// File: tb/tb_timer_mode_ctrl.sv
// Self-checking bench for timer_mode_ctrl with TICK_DIV=4, DB_CYCLES=2.
module tb_timer_mode_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_start = 1'b0;
  logic [7:0] preset = 8'd0;
  logic       sel;
  logic [7:0] count;
  logic       running;
  logic       done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] cnt;
    int         cyc;
    logic       dn;
  } exp_t;
  exp_t sb[$];

  timer_mode_ctrl #(.TICK_DIV(4), .DB_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_start(btn_start),
    .preset(preset), .sel(sel), .count(count), .running(running), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    btn_mode = 1'b0; btn_start = 1'b0; rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(3);
  endtask

  // Returns one sample point after the edge on which the FSM acts.
  task automatic press(input bit m, input bit s);
    btn_mode = m; btn_start = s;
    step(4);
    btn_mode = 1'b0; btn_start = 1'b0;
    step(1);
  endtask

  task automatic push(input logic [7:0] cnt, input int cyc, input logic dn);
    exp_t e;
    e.cnt = cnt; e.cyc = cyc; e.dn = dn;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    int k;
    rst_n = 1'b0;
    step(2);
    checks++;
    if ({sel, count, running, done} !== 11'd0) begin
      errors++; $display("FAIL reset_state: got %b expected %b", {sel, count, running, done}, 11'd0);
    end
    rst_n = 1'b1;
    step(3);
    btn_start = 1'b1; step(1); btn_start = 1'b0;
    step(8);
    checks++;
    if ({sel, count, running, done} !== 11'd0) begin
      errors++; $display("FAIL short_pulse_ignored: got %b expected %b", {sel, count, running, done}, 11'd0);
    end
    btn_start = 1'b1;
    k = 0;
    while (running !== 1'b1 && k < 10) begin step(1); k++; end
    checks++;
    if (running !== 1'b1) begin
      errors++; $display("FAIL held_start_runs: running=%b expected 1", running);
    end
    checks++;
    if (count !== 8'd0) begin
      errors++; $display("FAIL held_start_count: got %0d expected 0", count);
    end
    if (k < 10) step(10 - k);
    btn_start = 1'b0;
    step(8);
  endtask

  task automatic test_pause();
    do_reset();
    press(1'b0, 1'b1);
    step(8);
    btn_start = 1'b1;
    step(4);
    checks++;
    if (count !== 8'd3 || running !== 1'b1) begin
      errors++; $display("FAIL run_12_cycles: count=%0d running=%b expected 3 1", count, running);
    end
    btn_start = 1'b0;
    step(1);
    checks++;
    if (count !== 8'd3 || running !== 1'b0) begin
      errors++; $display("FAIL pause_entry: count=%0d running=%b expected 3 0", count, running);
    end
    for (int i = 0; i < 20; i++) begin
      step(1);
      checks++;
      if (count !== 8'd3 || running !== 1'b0) begin
        errors++; $display("FAIL pause_hold cyc %0d: count=%0d running=%b expected 3 0", i, count, running);
      end
    end
    press(1'b0, 1'b1);
    checks++;
    if (running !== 1'b1 || count !== 8'd3) begin
      errors++; $display("FAIL resume: running=%b count=%0d expected 1 3", running, count);
    end
    step(2);
    checks++;
    if (count !== 8'd3) begin
      errors++; $display("FAIL resume_early: count=%0d expected 3", count);
    end
    step(1);
    checks++;
    if (count !== 8'd4) begin
      errors++; $display("FAIL resume_partial_tick: count=%0d expected 4", count);
    end
  endtask

  task automatic test_countdown();
    exp_t e;
    do_reset();
    preset = 8'd3;
    press(1'b1, 1'b0);
    checks++;
    if (sel !== 1'b1 || count !== 8'd3 || running !== 1'b0) begin
      errors++; $display("FAIL mode_idle: sel=%b count=%0d running=%b expected 1 3 0", sel, count, running);
    end
    step(6);
    press(1'b0, 1'b1);
    checks++;
    if (running !== 1'b1 || count !== 8'd3) begin
      errors++; $display("FAIL cd_start: running=%b count=%0d expected 1 3", running, count);
    end
    preset = 8'd7;
    push(8'd3, 3, 1'b0); push(8'd2, 4, 1'b0); push(8'd2, 7, 1'b0);
    push(8'd1, 8, 1'b0); push(8'd0, 12, 1'b1); push(8'd0, 20, 1'b1);
    for (int c = 1; c <= 24; c++) begin
      step(1);
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        checks++;
        if (count !== e.cnt || done !== e.dn || running !== !e.dn) begin
          errors++;
          $display("FAIL countdown cyc %0d: count=%0d done=%b running=%b expected %0d %b %b",
                   c, count, done, running, e.cnt, e.dn, !e.dn);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL countdown_pending: %0d left expected 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_mode_ignored();
    do_reset();
    press(1'b0, 1'b1);
    step(6);
    press(1'b1, 1'b0);
    checks++;
    if (sel !== 1'b0 || running !== 1'b1) begin
      errors++; $display("FAIL mode_in_run: sel=%b running=%b expected 0 1", sel, running);
    end
    do_reset();
    preset = 8'd9;
    press(1'b1, 1'b0);
    step(6);
    press(1'b1, 1'b1);
    checks++;
    if (running !== 1'b1 || sel !== 1'b1 || count !== 8'd9) begin
      errors++; $display("FAIL both_pressed: running=%b sel=%b count=%0d expected 1 1 9", running, sel, count);
    end
  endtask

  task automatic test_done();
    do_reset();
    preset = 8'd0;
    press(1'b1, 1'b0);
    step(6);
    press(1'b0, 1'b1);
    checks++;
    if (running !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL zero_preset_run: running=%b done=%b expected 1 0", running, done);
    end
    step(1);
    checks++;
    if (done !== 1'b1 || running !== 1'b0 || count !== 8'd0) begin
      errors++; $display("FAIL zero_preset_done: done=%b running=%b count=%0d expected 1 0 0", done, running, count);
    end
    preset = 8'd6;
    step(6);
    press(1'b0, 1'b1);
    checks++;
    if (done !== 1'b0 || running !== 1'b0 || sel !== 1'b1 || count !== 8'd6) begin
      errors++;
      $display("FAIL done_to_idle: done=%b running=%b sel=%b count=%0d expected 0 0 1 6", done, running, sel, count);
    end
  endtask

  task automatic test_saturate();
    exp_t e;
    int   c;
    do_reset();
    press(1'b0, 1'b1);
    c = 0;
    while (count !== 8'd250 && c < 1100) begin step(1); c++; end
    checks++;
    if (count !== 8'd250) begin
      errors++; $display("FAIL reach_250: count=%0d expected 250", count);
    end
    push(8'd251, 4, 1'b0); push(8'd254, 16, 1'b0); push(8'd255, 20, 1'b0);
    push(8'd255, 23, 1'b0); push(8'd255, 24, 1'b1); push(8'd255, 40, 1'b1);
    for (int k = 1; k <= 40; k++) begin
      step(1);
      while (sb.size() > 0 && sb[0].cyc == k) begin
        e = sb.pop_front();
        checks++;
        if (count !== e.cnt || done !== e.dn || running !== !e.dn) begin
          errors++;
          $display("FAIL saturate cyc %0d: count=%0d done=%b running=%b expected %0d %b %b",
                   k, count, done, running, e.cnt, e.dn, !e.dn);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL saturate_pending: %0d left expected 0", sb.size());
    end
    sb.delete();
    press(1'b0, 1'b1);
    checks++;
    if (done !== 1'b0 || running !== 1'b0 || count !== 8'd0) begin
      errors++; $display("FAIL sw_done_to_idle: done=%b running=%b count=%0d expected 0 0 0", done, running, count);
    end
  endtask

  task automatic test_reset_mid_run();
    int c;
    do_reset();
    press(1'b0, 1'b1);
    c = 0;
    while (count !== 8'd5 && c < 40) begin step(1); c++; end
    checks++;
    if (count !== 8'd5) begin
      errors++; $display("FAIL reach_5: count=%0d expected 5", count);
    end
    btn_start = 1'b1;
    step(2);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({sel, count, running, done} !== 11'd0) begin
      errors++; $display("FAIL async_reset: got %b expected %b", {sel, count, running, done}, 11'd0);
    end
    step(3);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      checks++;
      if (running !== 1'b0) begin
        errors++; $display("FAIL held_after_reset cyc %0d: running=%b expected 0", i, running);
      end
    end
    btn_start = 1'b0;
    step(8);
    checks++;
    if (running !== 1'b0) begin
      errors++; $display("FAIL release_after_reset: running=%b expected 0", running);
    end
    press(1'b0, 1'b1);
    checks++;
    if (running !== 1'b1 || count !== 8'd0) begin
      errors++; $display("FAIL repress_after_reset: running=%b count=%0d expected 1 0", running, count);
    end
  endtask

  initial begin
    test_reset();
    test_pause();
    test_countdown();
    test_mode_ignored();
    test_done();
    test_saturate();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/timer_mode_ctrl.md
TIMER_MODE_CTRL -- requirements
Module: timer_mode_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 50000000, clock cycles per 1-second timer tick (min 2).
REQ-002 Parameter DB_CYCLES, default 1000000, cycles a synchronised button level must be stable before it is accepted (min 1).
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port btn_mode  input  1  raw, asynchronous mode push-button, high = pressed.
REQ-006 Port btn_start  input  1  raw, asynchronous start/stop push-button, high = pressed.
REQ-007 Port preset  input  8  countdown start value, sampled on start from IDLE.
REQ-008 Port sel  output  1  select to the 2-way display mux; 0 = stopwatch (in1), 1 = countdown (in2).
REQ-009 Port count  output  8  current timer value.
REQ-010 Port running  output  1  high only in state RUN.
REQ-011 Port done  output  1  high only in state DONE.
REQ-012 One clock; reset is asynchronous and active-low; all outputs driven from registers.

Function
REQ-013 Each button: 2-flop synchroniser, then debouncer; debounced level changes only after the synchronised level differs from it for DB_CYCLES consecutive cycles.
REQ-014 Each debounced 0->1 transition produces exactly one single-cycle press event; releases and bounces produce none.
REQ-015 FSM states: IDLE, RUN, PAUSE, DONE; press event acts on the next clock edge.
REQ-016 IDLE + mode press -> sel toggles, count loads 0 (sel=0) or preset (sel=1), state stays IDLE.
REQ-017 IDLE + start press -> RUN; count loads 0 if sel=0, preset if sel=1; prescaler clears.
REQ-018 IDLE + mode and start press same cycle -> start acts, mode ignored, sel unchanged.
REQ-019 RUN + start press -> PAUSE; PAUSE + start press -> RUN; count and prescaler hold in PAUSE (partial tick preserved).
REQ-020 Mode press ignored in RUN, PAUSE, DONE; sel never changes outside IDLE.
REQ-021 Prescaler counts 0..TICK_DIV-1 only in RUN, wraps to 0; tick = cycle where it equals TICK_DIV-1.
REQ-022 Stopwatch tick: count+1; on tick with count=255 -> count stays 255, state DONE (no wrap).
REQ-023 Countdown tick: count-1; tick that makes count 0 -> DONE same edge.
REQ-024 Countdown start with preset=0 -> RUN for one cycle then DONE, count=0, no tick needed.
REQ-025 RUN + start press on a tick cycle -> tick applied and state PAUSE (or DONE if terminal value reached; DONE wins).
REQ-026 DONE + start press -> IDLE; count reloads per REQ-016 rule for current sel; DONE holds otherwise.
REQ-027 preset changes are ignored except at IDLE load points (REQ-016, REQ-017, REQ-026).

Reset
REQ-028 rst_n low -> immediately: state IDLE, sel=0, count=0, running=0, done=0, prescaler=0, synchronisers/debouncers cleared to released.
REQ-029 Reset mid-RUN or mid-debounce discards all progress; no press event generated on release of reset even if a button is held (held button must be released and re-pressed).

Verification (TICK_DIV=4, DB_CYCLES=2)
REQ-030 Bench: reset, btn_start pulse 1 cycle wide -> no press event, state IDLE; held 10 cycles -> RUN, running=1, count=0.
REQ-031 Bench: stopwatch RUN 12 cycles -> count=3; start press -> PAUSE, count held 3 for 20 cycles; press -> RUN resumes without lost partial tick.
REQ-032 Bench: mode press in IDLE, preset=3, start -> sel=1, count 3->2->1->0 at 4-cycle spacing, done=1 at 0, running=0.
REQ-033 Bench: mode press during RUN -> sel unchanged; both buttons pressed same cycle in IDLE -> RUN, sel unchanged.
REQ-034 Bench: countdown preset=0 -> DONE after one cycle; stopwatch from 250 saturates at 255 with done=1; start in DONE -> IDLE.
REQ-035 Bench: rst_n low mid-RUN count=5 with btn_start held -> all outputs reset asynchronously; after rst_n high, no start until re-press.
